// File: rtl/bka_multiword_adder_seq.sv
// Multi-precision adder sequencer: streams one word pair per cycle through an
// external combinational adder, rippling the carry between words in a register.
module bka_multiword_adder_seq #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH*WORDS-1:0]   op_a,
  input  logic [WIDTH*WORDS-1:0]   op_b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH*WORDS-1:0]   sum,
  output logic                     cout,
  output logic [WIDTH-1:0]         adder_a,
  output logic [WIDTH-1:0]         adder_b,
  output logic                     adder_cin,
  input  logic [WIDTH-1:0]         adder_s,
  input  logic                     adder_cout
);

  localparam int unsigned TOTAL = WIDTH * WORDS;
  localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            carry;
  logic [TOTAL-1:0] a_reg;
  logic [TOTAL-1:0] b_reg;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;

  // Select the operand words addressed by idx.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < int'(WORDS); w++) begin
      if (idx == IDXW'(w)) begin
        a_word = a_reg[w*WIDTH +: WIDTH];
        b_word = b_reg[w*WIDTH +: WIDTH];
      end
    end
  end

  // The adder sees live operands only while a word is being summed.
  assign adder_a   = (state == ADD) ? a_word : '0;
  assign adder_b   = (state == ADD) ? b_word : '0;
  assign adder_cin = (state == ADD) ? carry  : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= op_a;
            b_reg <= op_b;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          for (int w = 0; w < int'(WORDS); w++) begin
            if (idx == IDXW'(w)) sum[w*WIDTH +: WIDTH] <= adder_s;
          end
          carry <= adder_cout;
          if (idx == LAST_IDX) begin
            cout  <= adder_cout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bka_multiword_adder_seq.sv
// Scoreboard bench for bka_multiword_adder_seq with a behavioural adder attached.
module tb_bka_multiword_adder_seq;
  localparam int unsigned W = 31;
  localparam int unsigned WORDS = 4;
  localparam int unsigned N = W * WORDS;

  logic clk = 1'b0;
  logic reset, start, cin;
  logic [N-1:0] op_a, op_b;
  logic busy, done, cout;
  logic [N-1:0] sum;
  logic [W-1:0] adder_a, adder_b, adder_s;
  logic adder_cin, adder_cout;
  logic [W:0] add_res;

  always #5 clk = ~clk;

  assign add_res    = {1'b0, adder_a} + {1'b0, adder_b} + (W+1)'(adder_cin);
  assign adder_s    = add_res[W-1:0];
  assign adder_cout = add_res[W];

  bka_multiword_adder_seq #(.WIDTH(W), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout)
  );

  typedef struct packed {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [N-1:0]     sum;
    logic             cout;
    logic [WORDS-1:0] cins;
    int unsigned      dcyc;
  } exp_t;

  exp_t exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: whole-operand arithmetic; the carry into word w is bit W*w
  // of the sum of the operands truncated below that word.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input int unsigned dcyc);
    exp_t e;
    logic [N:0] full, m, lo;
    full = {1'b0, a} + {1'b0, b} + (N+1)'(c);
    e.a = a;
    e.b = b;
    e.sum = full[N-1:0];
    e.cout = full[N];
    e.dcyc = dcyc;
    for (int w = 0; w < int'(WORDS); w++) begin
      m  = ((N+1)'(1) << (W * w)) - (N+1)'(1);
      lo = ({1'b0, a} & m) + ({1'b0, b} & m) + (N+1)'(c);
      e.cins[w] = lo[W * w];
    end
    return e;
  endfunction

  // Monitor: collect adder traffic during ADD, score results on done.
  logic [W-1:0] rec_a[$], rec_b[$];
  logic         rec_c[$];
  always @(negedge clk) begin
    if (busy && !done) begin
      rec_a.push_back(adder_a);
      rec_b.push_back(adder_b);
      rec_c.push_back(adder_cin);
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'(done), 128'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 128'(sum), 128'(e.sum));
        check("cout", 128'(cout), 128'(e.cout));
        check("done_cycle", 128'(cyc), 128'(e.dcyc));
        check("busy_at_done", 128'(busy), 128'(1));
        check("add_cycles", 128'(rec_a.size()), 128'(WORDS));
        for (int w = 0; w < int'(WORDS) && w < rec_a.size(); w++) begin
          check("adder_a_word", 128'(rec_a[w]), 128'(e.a[w*W +: W]));
          check("adder_b_word", 128'(rec_b[w]), 128'(e.b[w*W +: W]));
          check("adder_cin_word", 128'(rec_c[w]), 128'(e.cins[w]));
        end
      end
      rec_a.delete(); rec_b.delete(); rec_c.delete();
    end else begin
      if (busy == 1'b0) begin
        check("idle_adder_a", 128'(adder_a), 128'(0));
      end
      rec_a.delete(); rec_b.delete(); rec_c.delete();
    end
  end

  function automatic logic [N-1:0] rnd_op();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[N-1:0];
  endfunction

  // Issue one operation from IDLE; operand inputs are scrambled afterwards.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cin = c;
    exp_q.push_back(model(a, b, c, cyc + 1 + WORDS));
    @(negedge clk);
    start = 1'b0; op_a = rnd_op(); op_b = rnd_op(); cin = $urandom_range(0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [N-1:0] ONES  = {N{1'b1}};
  localparam logic [N-1:0] ALT_A = {WORDS{31'h2aaa_aaaa}};
  localparam logic [N-1:0] ALT_B = {WORDS{31'h5555_5555}};

  initial begin
    reset = 1'b1; start = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_sum", 128'(sum), 128'(0));
    check("rst_cout", 128'(cout), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_adder_cin", 128'(adder_cin), 128'(0));
    reset = 1'b0;

    issue('0, '0, 1'b0);      drain();
    issue(ONES, '0, 1'b1);    drain();
    issue(ALT_A, ALT_B, 1'b0); drain();
    issue(ALT_A, ALT_B, 1'b1); drain();
    issue(ONES, ONES, 1'b1);  drain();

    // start during ADD with new operands is ignored
    issue(ALT_A, ALT_B, 1'b1);
    start = 1'b1; op_a = ONES; op_b = ONES; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset during ADD word 2 aborts the run
    @(negedge clk);
    start = 1'b1; op_a = ONES; op_b = ONES; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_sum", 128'(sum), 128'(0));
    check("abort_cout", 128'(cout), 128'(0));
    repeat (8) @(negedge clk);

    // start held high: one operation every WORDS+2 cycles
    start = 1'b1; op_a = ALT_A; op_b = ALT_B; cin = 1'b0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(model(ALT_A, ALT_B, 1'b0, cyc + 1 + WORDS + k * (WORDS + 2)));
    repeat (4 * (WORDS + 2)) @(negedge clk);
    start = 1'b0;
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      drain();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bka_multiword_adder_seq.md
Name: bka_multiword_adder_seq

Overview:
Sequencer that performs multi-precision addition of WORDS×WIDTH-bit operands by streaming one WIDTH-bit word pair per cycle through the existing combinational 31-bit Brent-Kung adder (BKA_Teir2).
- Sits directly upstream of the adder: drives its A/B/Cin, consumes its S/Cout, and ripples the carry word-to-word in a register.
- Exposes a start/busy/done interface to the datapath above.

Parameters:
- WIDTH, 31, word width; must equal the attached adder width.
- WORDS, 4, number of words per operand; ≥1. Full operand width is WIDTH*WORDS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH*WORDS  operand A; word 0 = bits [WIDTH-1:0].
- op_b  input  WIDTH*WORDS  operand B.
- cin  input  1  carry into word 0.
- busy  output  1  high in ADD and DONE.
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH*WORDS  registered result.
- cout  output  1  registered carry out of the top word.
- adder_a  output  WIDTH  to adder A.
- adder_b  output  WIDTH  to adder B.
- adder_cin  output  1  to adder Cin.
- adder_s  input  WIDTH  from adder S (combinational, same cycle).
- adder_cout  input  1  from adder Cout.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, cout=0, busy=0, done=0. Reset wins over every other event, including mid-ADD: the partial sum is discarded and the module returns to IDLE on the next edge.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - adder_a, adder_b and adder_cin are driven 0.
  - If start=1: latch op_a→a_reg, op_b→b_reg, cin→carry; set idx=0; go to ADD.
  - sum and cout hold their previous values until the first ADD cycle overwrites them word by word.
- ADD, each cycle:
  - Drive adder_a=a_reg word idx, adder_b=b_reg word idx, adder_cin=carry.
  - On the edge, capture adder_s into sum word idx and adder_cout into carry.
  - If idx==WORDS-1: cout←adder_cout, go to DONE. Otherwise idx←idx+1.
- DONE: done=1 for exactly one cycle, busy=1, adder inputs driven 0; go to IDLE unconditionally.
- start is ignored in ADD and DONE; there is no queueing. op_a/op_b/cin may change freely after the start cycle.
- Latency: start sampled at edge N; ADD occupies cycles N+1..N+WORDS; done is high in cycle N+WORDS+1. Back-to-back: the next start is accepted in the cycle after done, giving a throughput of 1 operation per WORDS+2 cycles.
- Width rules:
  - idx is $clog2(WORDS) bits, minimum 1.
  - No overflow is flagged other than cout.
  - The result equals (op_a + op_b + cin) mod 2^(WIDTH*WORDS), with cout as bit WIDTH*WORDS.
- WORDS=1: a single ADD cycle, then DONE.
- sum and cout are stable from done through the next start (and held after reset at 0).

Test Plan:
- Zeros: WORDS=4, op_a=op_b=0, cin=0, start → done 5 cycles after start edge; sum=0, cout=0; adder_cin=0 every ADD cycle.
- Full carry ripple: op_a=all ones (124 bits), op_b=0, cin=1 → sum=0, cout=1; adder_cin=1 in all 4 ADD cycles; busy high for 5 cycles.
- Alternating: every word of op_a=31'h2aaa_aaaa, every word of op_b=31'h5555_5555, cin=0 → every sum word=31'h7fff_ffff, cout=0; same operands with cin=1 → sum=0, cout=1.
- Max+max: op_a=op_b=all ones, cin=1 → sum=all ones, cout=1; word 0 adder_s=31'h7fff_ffff with adder_cout=1.
- Busy-start/reset: start pulsed again during ADD with new operands → ignored, first result unchanged; a second run with reset asserted during ADD word 2 → next cycle state IDLE, busy=0, done never pulses, sum=0, cout=0.
- Back-to-back: start held high continuously with alternating/cin=0 operands → done pulses every 6 cycles with sum words=31'h7fff_ffff each time.
